// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//   Memory-access stage of the pipelined processor. Consumes the EX/MEM
//   pipeline register, runs a multi-cycle request/acknowledge access to data
//   memory, stalls upstream while that access is outstanding, resolves
//   branches, and loads the MEM/WB pipeline register.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   in_valid            EX/MEM slot holds a real instruction (0 = bubble)
//   m[2:0]              {branch, memread, memwrite}
//   wb[2:0]             {regwrite, memtoreg, spare}, passed to MEM/WB
//   pc, zero            branch target and ALU zero flag from EX
//   alu_result          ALU result / memory byte address
//   writedata           store data
//   ex_rd               destination register
//   stall               freeze PC, IF/ID, ID/EX, EX/MEM this cycle
//   pcsrc               take branch (combinational)
//   branch_target       equals pc
//   misalign            one-cycle pulse: bad memory op dropped
//   dmem_req/we/addr/wdata   registered request, held until dmem_ack
//   dmem_ack, dmem_rdata     completion strobe and load data
//   wb_valid, wb_ctrl, wb_rd, wb_alu_result, wb_read_data   MEM/WB register
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [2:0]        m,
    input  logic [2:0]        wb,
    input  logic [31:0]       pc,
    input  logic              zero,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       writedata,
    input  logic [4:0]        ex_rd,
    output logic              stall,
    output logic              pcsrc,
    output logic [31:0]       branch_target,
    output logic              misalign,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic [2:0]        wb_ctrl,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_alu_result,
    output logic [31:0]       wb_read_data
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;

    logic [0:0] state;
    logic       memop;
    logic       bad;
    logic       good_memop;

    assign memop      = in_valid & (m[1] | m[0]);
    // Word-misaligned addresses and the illegal read+write encoding are dropped.
    assign bad        = memop & ((alu_result[1:0] != 2'b00) | (m[1] & m[0]));
    assign good_memop = memop & ~bad;

    assign branch_target = pc;

    // NOTE: every output of a combinational block gets a default first so
    // that no path leaves it unassigned and a latch is inferred.
    always_comb begin
        stall    = 1'b0;
        misalign = 1'b0;
        pcsrc    = 1'b0;
        if (state == S_IDLE) begin
            stall    = good_memop;
            misalign = bad;
            pcsrc    = in_valid & m[2] & zero;
        end else begin
            // Upstream advances in the ack cycle itself.
            stall = ~dmem_ack;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            wb_valid      <= 1'b0;
            wb_ctrl       <= 3'b000;
            wb_rd         <= 5'd0;
            wb_alu_result <= 32'd0;
            wb_read_data  <= 32'd0;
        end else begin
            // Default: MEM/WB takes a bubble; rd/alu/read data simply hold.
            wb_valid <= 1'b0;
            wb_ctrl  <= 3'b000;
            case (state)
                S_IDLE: begin
                    if (good_memop) begin
                        dmem_addr  <= ADDR_W'(alu_result);
                        dmem_wdata <= DATA_W'(writedata);
                        dmem_we    <= m[0];
                        dmem_req   <= 1'b1;
                        state      <= S_ACCESS;
                    end else if (in_valid && !memop) begin
                        wb_valid      <= 1'b1;
                        wb_ctrl       <= wb;
                        wb_rd         <= ex_rd;
                        wb_alu_result <= alu_result;
                    end
                end
                S_ACCESS: begin
                    // Inputs are frozen by stall, so m/wb/ex_rd still describe
                    // the instruction that issued this access.
                    if (dmem_ack) begin
                        dmem_req      <= 1'b0;
                        wb_valid      <= 1'b1;
                        wb_ctrl       <= wb;
                        wb_rd         <= ex_rd;
                        wb_alu_result <= alu_result;
                        if (m[1]) begin
                            wb_read_data <= 32'(dmem_rdata);
                        end
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//   Directed bench for mem_stage: a table of single-cycle vectors applied from
//   IDLE, then hand-written load, store and reset-during-access sequences.
//   Inputs change on the falling edge; combinational outputs are sampled 1ns
//   later, registered outputs at the following falling edge.
// ---------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [2:0]  m;
    logic [2:0]  wb;
    logic [31:0] pc;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] writedata;
    logic [4:0]  ex_rd;
    logic        stall;
    logic        pcsrc;
    logic [31:0] branch_target;
    logic        misalign;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [2:0]  wb_ctrl;
    logic [4:0]  wb_rd;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_read_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .m(m), .wb(wb), .pc(pc),
        .zero(zero), .alu_result(alu_result), .writedata(writedata),
        .ex_rd(ex_rd), .stall(stall), .pcsrc(pcsrc),
        .branch_target(branch_target), .misalign(misalign),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_ctrl(wb_ctrl), .wb_rd(wb_rd),
        .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [2:0] mm, input logic [2:0] w,
                         input logic [31:0] p, input logic z, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        in_valid   = iv;
        m          = mm;
        wb         = w;
        pc         = p;
        zero       = z;
        alu_result = a;
        writedata  = wd;
        ex_rd      = rd;
    endtask

    typedef struct {
        string       name;
        logic        iv;
        logic [2:0]  m;
        logic [2:0]  wb;
        logic [31:0] pc;
        logic        zero;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        e_stall;
        logic        e_pcsrc;
        logic        e_misalign;
        logic        e_wb_valid;
        logic [2:0]  e_wb_ctrl;
    } vec_t;

    vec_t vecs[10];
    int   stall_cycles;

    initial begin
        vecs[0] = '{"alu_op",     1'b1, 3'b000, 3'b100, 32'h0,  1'b0, 32'h1234,     5'd5,  1'b0, 1'b0, 1'b0, 1'b1, 3'b100};
        vecs[1] = '{"bubble",     1'b0, 3'b000, 3'b100, 32'h0,  1'b0, 32'h55,       5'd9,  1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
        vecs[2] = '{"ld_mis",     1'b1, 3'b010, 3'b110, 32'h0,  1'b0, 32'h102,      5'd4,  1'b0, 1'b0, 1'b1, 1'b0, 3'b000};
        vecs[3] = '{"br_taken",   1'b1, 3'b100, 3'b000, 32'h80, 1'b1, 32'h0,        5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 3'b000};
        vecs[4] = '{"br_not",     1'b1, 3'b100, 3'b000, 32'h80, 1'b0, 32'h4,        5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 3'b000};
        vecs[5] = '{"rw_both",    1'b1, 3'b011, 3'b100, 32'h0,  1'b0, 32'h200,      5'd2,  1'b0, 1'b0, 1'b1, 1'b0, 3'b000};
        vecs[6] = '{"st_mis",     1'b1, 3'b001, 3'b000, 32'h0,  1'b0, 32'h41,       5'd1,  1'b0, 1'b0, 1'b1, 1'b0, 3'b000};
        vecs[7] = '{"alu_op2",    1'b1, 3'b000, 3'b110, 32'h0,  1'b0, 32'hFFFFFFFF, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1, 3'b110};
        vecs[8] = '{"bub_ld",     1'b0, 3'b010, 3'b110, 32'h0,  1'b0, 32'h100,      5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
        vecs[9] = '{"bub_br",     1'b0, 3'b100, 3'b000, 32'h90, 1'b1, 32'h0,        5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 3'b000};

        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        drive(1'b0, 3'b000, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst_req",      {31'd0, dmem_req},  32'd0);
        check("rst_we",       {31'd0, dmem_we},   32'd0);
        check("rst_addr",     dmem_addr,          32'd0);
        check("rst_wdata",    dmem_wdata,         32'd0);
        check("rst_wb_valid", {31'd0, wb_valid},  32'd0);
        check("rst_wb_ctrl",  {29'd0, wb_ctrl},   32'd0);
        check("rst_wb_rd",    {27'd0, wb_rd},     32'd0);
        check("rst_wb_alu",   wb_alu_result,      32'd0);
        check("rst_wb_rdata", wb_read_data,       32'd0);
        rst = 1'b0;
        #1;
        check("rst_stall",    {31'd0, stall},     32'd0);
        check("rst_misalign", {31'd0, misalign},  32'd0);
        @(negedge clk);

        // Single-cycle vectors, each applied from IDLE.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].iv, vecs[i].m, vecs[i].wb, vecs[i].pc, vecs[i].zero,
                  vecs[i].alu, 32'hCAFE0000, vecs[i].rd);
            #1;
            check({vecs[i].name, "_stall"},    {31'd0, stall},    {31'd0, vecs[i].e_stall});
            check({vecs[i].name, "_pcsrc"},    {31'd0, pcsrc},    {31'd0, vecs[i].e_pcsrc});
            check({vecs[i].name, "_misalign"}, {31'd0, misalign}, {31'd0, vecs[i].e_misalign});
            check({vecs[i].name, "_target"},   branch_target,     vecs[i].pc);
            @(negedge clk);
            check({vecs[i].name, "_wb_valid"}, {31'd0, wb_valid}, {31'd0, vecs[i].e_wb_valid});
            check({vecs[i].name, "_wb_ctrl"},  {29'd0, wb_ctrl},  {29'd0, vecs[i].e_wb_ctrl});
            check({vecs[i].name, "_req"},      {31'd0, dmem_req}, 32'd0);
            if (vecs[i].e_wb_valid) begin
                check({vecs[i].name, "_wb_rd"},  {27'd0, wb_rd}, {27'd0, vecs[i].rd});
                check({vecs[i].name, "_wb_alu"}, wb_alu_result,  vecs[i].alu);
            end
        end

        // Load at 0x100, ack arrives 3 cycles after the request appears.
        stall_cycles = 0;
        drive(1'b1, 3'b010, 3'b110, 32'h0, 1'b0, 32'h100, 32'h0, 5'd7);
        for (int c = 0; c < 4; c++) begin
            #1;
            if (stall) stall_cycles++;
            @(negedge clk);
            check("ld_req_held",  {31'd0, dmem_req}, 32'd1);
            check("ld_wb_bubble", {31'd0, wb_valid}, 32'd0);
        end
        check("ld_addr", dmem_addr,               32'h100);
        check("ld_we",   {31'd0, dmem_we},        32'd0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        #1;
        check("ld_ack_stall", {31'd0, stall}, 32'd0);
        check("ld_stall_cycles", stall_cycles, 32'd4);
        @(negedge clk);
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        check("ld_req_drop", {31'd0, dmem_req},  32'd0);
        check("ld_wb_valid", {31'd0, wb_valid},  32'd1);
        check("ld_wb_ctrl",  {29'd0, wb_ctrl},   32'd6);
        check("ld_wb_rd",    {27'd0, wb_rd},     32'd7);
        check("ld_wb_alu",   wb_alu_result,      32'h100);
        check("ld_rdata",    wb_read_data,       32'hDEADBEEF);
        // Bubble behind the load; a stray ack in IDLE must be ignored.
        drive(1'b0, 3'b000, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h11111111;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("ld_wb_once",   {31'd0, wb_valid}, 32'd0);
        check("idle_ack_req", {31'd0, dmem_req}, 32'd0);
        check("idle_ack_rd",  wb_read_data,      32'hDEADBEEF);

        // Store at 0x40 acked in the same cycle the request appears.
        drive(1'b1, 3'b001, 3'b000, 32'h0, 1'b0, 32'h40, 32'hA5A5A5A5, 5'd3);
        #1;
        check("st_issue_stall", {31'd0, stall}, 32'd1);
        @(negedge clk);
        check("st_req",   {31'd0, dmem_req}, 32'd1);
        check("st_we",    {31'd0, dmem_we},  32'd1);
        check("st_addr",  dmem_addr,         32'h40);
        check("st_wdata", dmem_wdata,        32'hA5A5A5A5);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h22222222;
        #1;
        check("st_ack_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        dmem_ack = 1'b0;
        check("st_wb_valid", {31'd0, wb_valid},   32'd1);
        check("st_regwrite", {31'd0, wb_ctrl[2]}, 32'd0);
        check("st_req_drop", {31'd0, dmem_req},   32'd0);
        check("st_rdata",    wb_read_data,        32'hDEADBEEF);
        // Non-memory op after the store leaves load data untouched.
        drive(1'b1, 3'b000, 3'b100, 32'h0, 1'b0, 32'h77, 32'h0, 5'd8);
        @(negedge clk);
        check("alu_rdata_hold", wb_read_data,  32'hDEADBEEF);
        check("alu_after_st",   wb_alu_result, 32'h77);

        // Reset during ACCESS, then a late ack.
        drive(1'b1, 3'b010, 3'b100, 32'h0, 1'b0, 32'h300, 32'h0, 5'd12);
        @(negedge clk);
        check("ra_req", {31'd0, dmem_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 3'b000, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);
        check("ra_req_drop",  {31'd0, dmem_req}, 32'd0);
        check("ra_wb_valid",  {31'd0, wb_valid}, 32'd0);
        check("ra_wb_ctrl",   {29'd0, wb_ctrl},  32'd0);
        check("ra_wb_rd",     {27'd0, wb_rd},    32'd0);
        check("ra_wb_alu",    wb_alu_result,     32'd0);
        check("ra_wb_rdata",  wb_read_data,      32'd0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h12345678;
        #1;
        check("ra_ack_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        dmem_ack = 1'b0;
        check("ra_late_req",   {31'd0, dmem_req}, 32'd0);
        check("ra_late_valid", {31'd0, wb_valid}, 32'd0);
        check("ra_late_rdata", wb_read_data,      32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
